// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//  - MDU operation encodings, as presented on the op port
//  - FSM state encoding for the top-level sequencer
//  - Divide latency constant (one quotient bit per cycle)
//  - Restoring-division step and magnitude helpers used by the divider
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } mdu_state_e;

  // Partial remainder / quotient pair carried from one divide step to the next.
  typedef struct packed {
    logic [31:0] rem;
    logic [31:0] quo;
  } div_pair_t;

  // One restoring-division step. The dividend is shifted out of quo (MSB first)
  // into rem while quotient bits are shifted in at the bottom of quo. Because
  // rem < dvs always holds, the shifted value fits in 33 bits and bit 32 of
  // the difference is a clean "went negative" flag.
  function automatic div_pair_t div_step(input logic [31:0] rem,
                                         input logic [31:0] quo,
                                         input logic [31:0] dvs);
    logic [32:0] shifted;
    logic [32:0] diff;
    div_pair_t   res;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
    if (diff[32] == 1'b0) begin
      res.rem = diff[31:0];
      res.quo = {quo[30:0], 1'b1};
    end else begin
      res.rem = shifted[31:0];
      res.quo = {quo[30:0], 1'b0};
    end
    return res;
  endfunction

  // Magnitude of a 32-bit operand; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    logic [31:0] res;
    if (is_signed && v[31]) begin
      res = 32'd0 - v;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_div_unit_serial_divider.sv
// serial_divider: restoring divider, one quotient bit per clock, working on
// operand magnitudes. Sign fix-up is left to the caller.
// Ports:
//  clk        in   clock, rising edge
//  reset      in   asynchronous active-high reset; abandons any division
//  start      in   load new operands (first step is taken on this edge)
//  dividend   in   32-bit dividend
//  divisor    in   32-bit divisor
//  is_signed  in   treat operands as two's complement (magnitudes are used)
//  quotient   out  magnitude quotient, valid when done
//  remainder  out  magnitude remainder, valid when done
//  done       out  all DIV_CYCLES steps have been taken since the last start
module serial_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam logic [5:0] STEP_LAST = 6'(DIV_CYCLES);

  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [5:0]  steps_r;
  logic        active_r;
  div_pair_t   first_s;
  div_pair_t   next_s;

  // First step is taken straight from the incoming operands so that the last
  // of the DIV_CYCLES steps lands one edge before the caller's result edge.
  always_comb begin
    first_s = div_step(32'd0, abs32(dividend, is_signed), abs32(divisor, is_signed));
  end

  // Subsequent steps operate on the registered partial results.
  always_comb begin
    next_s = div_step(rem_r, quo_r, dvs_r);
  end

  // Shift/subtract datapath and step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      dvs_r    <= 32'd0;
      steps_r  <= 6'd0;
      active_r <= 1'b0;
    end else if (start) begin
      rem_r    <= first_s.rem;
      quo_r    <= first_s.quo;
      dvs_r    <= abs32(divisor, is_signed);
      steps_r  <= 6'd1;
      active_r <= 1'b1;
    end else if (active_r && (steps_r != STEP_LAST)) begin
      rem_r    <= next_s.rem;
      quo_r    <= next_s.quo;
      steps_r  <= steps_r + 6'd1;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign done      = active_r && (steps_r == STEP_LAST);

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multiply/divide unit with architectural HI/LO registers for
// the EX stage of the 5-stage MIPS core. Multi-cycle operations run beside
// the pipeline; busy lets the hazard unit stall MFHI/MFLO and new MDU ops.
// Ports:
//  clk    in   clock, rising edge
//  reset  in   asynchronous active-high reset
//  start  in   valid MDU instruction in EX, sampled on the rising edge
//  op     in   3-bit operation (MULT, MULTU, DIV, DIVU, MTHI, MTLO; 11x no-op)
//  a      in   rs operand (forwarded)
//  b      in   rt operand (forwarded)
//  busy   out  registered; a multi-cycle operation is in flight
//  hi     out  HI register
//  lo     out  LO register
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  mdu_state_e  state_r;
  mdu_state_e  state_nxt_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_nxt_s;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] hi_nxt_s;
  logic [31:0] lo_nxt_s;
  logic        busy_r;
  logic        busy_nxt_s;

  // Instruction decode; new work is only accepted while idle.
  logic        idle_s;
  logic        start_mul_s;
  logic        start_div_s;
  logic        start_mthi_s;
  logic        start_mtlo_s;
  logic        div_signed_s;

  // Multiply operands, held as 33-bit values whose top bit is the sign
  // extension (zero for MULTU) so one product serves both signednesses.
  logic [32:0] mul_a_r;
  logic [32:0] mul_b_r;
  logic [63:0] mul_a_ext_s;
  logic [63:0] mul_b_ext_s;
  logic [63:0] mul_prod_s;

  // Divide context kept for the result edge.
  logic [31:0] div_a_r;
  logic        div_zero_r;
  logic        div_neg_q_r;
  logic        div_neg_r_r;
  logic [31:0] div_quo_s;
  logic [31:0] div_rem_s;
  logic        div_done_s;
  logic [31:0] div_quo_fix_s;
  logic [31:0] div_rem_fix_s;

  assign idle_s       = (state_r == ST_IDLE);
  assign start_mul_s  = start && idle_s && ((op == MDU_MULT) || (op == MDU_MULTU));
  assign start_div_s  = start && idle_s && ((op == MDU_DIV) || (op == MDU_DIVU));
  assign start_mthi_s = start && idle_s && (op == MDU_MTHI);
  assign start_mtlo_s = start && idle_s && (op == MDU_MTLO);
  assign div_signed_s = (op == MDU_DIV);

  serial_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (start_div_s),
    .dividend  (a),
    .divisor   (b),
    .is_signed (div_signed_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s),
    .done      (div_done_s)
  );

  // Product of the latched operands; the low 64 bits of the sign-extended
  // product are correct for both signed and unsigned multiplication.
  always_comb begin
    mul_a_ext_s = {{31{mul_a_r[32]}}, mul_a_r};
    mul_b_ext_s = {{31{mul_b_r[32]}}, mul_b_r};
    mul_prod_s  = mul_a_ext_s * mul_b_ext_s;
  end

  // Divide result sign fix-up (truncating division); divide-by-zero bypasses it.
  always_comb begin
    if (div_zero_r) begin
      div_quo_fix_s = 32'hFFFF_FFFF;
      div_rem_fix_s = div_a_r;
    end else begin
      div_quo_fix_s = div_neg_q_r ? (32'd0 - div_quo_s) : div_quo_s;
      div_rem_fix_s = div_neg_r_r ? (32'd0 - div_rem_s) : div_rem_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_mul_s) begin
          state_nxt_s = ST_MUL;
        end else if (start_div_s) begin
          state_nxt_s = ST_DIV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == 5'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DIV: begin
        if ((cnt_r == 5'd0) && div_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: counter, HI/LO and busy next values.
  always_comb begin
    cnt_nxt_s = cnt_r;
    hi_nxt_s  = hi_r;
    lo_nxt_s  = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start_mul_s) begin
          cnt_nxt_s = MUL_LOAD;
        end else if (start_div_s) begin
          cnt_nxt_s = DIV_LOAD;
        end else if (start_mthi_s) begin
          hi_nxt_s = a;
        end else if (start_mtlo_s) begin
          lo_nxt_s = a;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_MUL: begin
        if (cnt_r == 5'd0) begin
          hi_nxt_s = mul_prod_s[63:32];
          lo_nxt_s = mul_prod_s[31:0];
        end else begin
          cnt_nxt_s = cnt_r - 5'd1;
        end
      end
      ST_DIV: begin
        if (cnt_r != 5'd0) begin
          cnt_nxt_s = cnt_r - 5'd1;
        end else if (div_done_s) begin
          hi_nxt_s = div_rem_fix_s;
          lo_nxt_s = div_quo_fix_s;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        cnt_nxt_s = 5'd0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Architectural registers, counter, busy flag and operand latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= 5'd0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      busy_r      <= 1'b0;
      mul_a_r     <= 33'd0;
      mul_b_r     <= 33'd0;
      div_a_r     <= 32'd0;
      div_zero_r  <= 1'b0;
      div_neg_q_r <= 1'b0;
      div_neg_r_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      hi_r   <= hi_nxt_s;
      lo_r   <= lo_nxt_s;
      busy_r <= busy_nxt_s;
      if (start_mul_s) begin
        mul_a_r <= {(op == MDU_MULT) && a[31], a};
        mul_b_r <= {(op == MDU_MULT) && b[31], b};
      end
      if (start_div_s) begin
        div_a_r     <= a;
        div_zero_r  <= (b == 32'd0);
        div_neg_q_r <= div_signed_s && (a[31] ^ b[31]);
        div_neg_r_r <= div_signed_s && a[31];
      end
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model of HI/LO.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit #(.MUL_CYCLES(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] o);
    int l;
    case (o)
      OP_MULT, OP_MULTU: l = 5;
      OP_DIV, OP_DIVU:   l = 32;
      default:           l = 0;
    endcase
    return l;
  endfunction

  // Reference model: HI/LO after an operation, from plain arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          ps;
    longint          qs;
    longint          rs;
    logic [63:0]     pu;
    case (o)
      OP_MULT: begin
        ps   = longint'($signed(x)) * longint'($signed(y));
        m_hi = ps[63:32];
        m_lo = ps[31:0];
      end
      OP_MULTU: begin
        pu   = {32'd0, x} * {32'd0, y};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      OP_DIV: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = x;
        end else begin
          qs   = longint'($signed(x)) / longint'($signed(y));
          rs   = longint'($signed(x)) % longint'($signed(y));
          m_lo = qs[31:0];
          m_hi = rs[31:0];
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = x;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      OP_MTHI: m_hi = x;
      OP_MTLO: m_lo = x;
      default: ;
    endcase
  endtask

  // Issue one op at a negedge, scramble the operand buses while busy
  // (optionally also holding start with an MTLO), then check latency and HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit disturb);
    int          cycles;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    @(negedge clk);
    start  = disturb;
    if (disturb) op = OP_MTLO;
    a      = $urandom;
    b      = $urandom;
    cycles = 0;
    while ((busy === 1'b1) && (cycles < 200)) begin
      cycles++;
      check("hold_hi", hi, old_hi);
      check("hold_lo", lo, old_lo);
      @(negedge clk);
      a = $urandom;
      b = $urandom;
    end
    start = 1'b0;
    check("latency", cycles, lat_of(o));
    model(o, x, y);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    reset = 1'b1;
    start = 1'b0;
    op    = OP_NOP;
    a     = 32'd0;
    b     = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    #12;
    check("rst_busy", busy, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed corner cases.
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(OP_DIVU,  32'd100, 32'd7, 1'b0);
    run_op(OP_DIVU,  32'h0000_1234, 32'd0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FF00, 32'd0, 1'b0);
    run_op(OP_MTHI,  32'hA5A5_A5A5, 32'd0, 1'b0);
    run_op(OP_MTLO,  32'h5A5A_5A5A, 32'd0, 1'b0);
    run_op(OP_DIV,   32'd1000, 32'hFFFF_FFF9, 1'b1);
    run_op(OP_NOP,   32'h1111_1111, 32'h2222_2222, 1'b0);
    run_op(3'b111,   32'h3333_3333, 32'h4444_4444, 1'b0);

    // Random operations with biased operand classes.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 4))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 9));
        2: rx = 32'($urandom_range(0, 200));
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, rx, ry, ((ro == OP_DIV) || (ro == OP_DIVU)) && ($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset in the middle of a divide.
    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd12345;
    b     = 32'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", busy, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    run_op(OP_MULTU, 32'd3, 32'd4, 1'b0);
    check("post_rst_lo", lo, 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
